// File: rtl/csi2_pkt_ctrl.sv
// csi2_pkt_ctrl: CSI-2 packet sequencer after the header Hamming decoder.
// Parses the packet header (DI, WC), emits short-packet events, forwards
// long-packet payload with byte enables, aborts on oversize WC, bad headers
// or idle timeout, and strobes pkt_done_o at every packet boundary.
// Ports:
//   clk_i, srst_i (async, active-high)
//   dec_*_i          : corrected word stream and error flags from the decoder
//   pkt_done_o       : one-cycle packet-end/flush strobe
//   pld_*_o          : payload stream (data, keep, last, dt, vc)
//   evt_*_o          : short-packet event (dt, 16-bit data field)
//   pkt_abort_o      : one-cycle abort strobe
//   *_cnt_o          : saturating statistics counters
module csi2_pkt_ctrl #(
  parameter logic [15:0] MAX_WC  = 16'd8192,
  parameter logic [3:0]  VC_EN   = 4'b1111,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             dec_valid_i,
  input  logic [31:0]      dec_data_i,
  input  logic             dec_error_i,
  input  logic             dec_error_corrected_i,
  output logic             pkt_done_o,
  output logic             pld_valid_o,
  output logic [31:0]      pld_data_o,
  output logic [3:0]       pld_keep_o,
  output logic             pld_last_o,
  output logic [5:0]       pld_dt_o,
  output logic [1:0]       pld_vc_o,
  output logic             evt_valid_o,
  output logic [5:0]       evt_dt_o,
  output logic [15:0]      evt_data_o,
  output logic             pkt_abort_o,
  output logic [CNT_W-1:0] hdr_corr_cnt_o,
  output logic [CNT_W-1:0] hdr_err_cnt_o,
  output logic [CNT_W-1:0] abort_cnt_o
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             state_q;
  logic [15:0]        idx_q;      // index of the next payload-phase word
  logic [15:0]        nfwd_q;     // words carrying payload bytes
  logic [15:0]        total_q;    // payload + CRC footer words
  logic [1:0]         wc_mod_q;
  logic [IDLE_W-1:0]  idle_q;
  logic               open_q;     // payload forwarded, last beat not yet sent

  logic               pkt_done_q, pld_valid_q, pld_last_q, evt_valid_q, pkt_abort_q;
  logic [31:0]        pld_data_q;
  logic [3:0]         pld_keep_q;
  logic [5:0]         pld_dt_q, evt_dt_q;
  logic [1:0]         pld_vc_q;
  logic [15:0]        evt_data_q;
  logic [CNT_W-1:0]   hdr_corr_cnt_q, hdr_err_cnt_q, abort_cnt_q;

  logic [5:0]         hdr_dt;
  logic [1:0]         hdr_vc;
  logic [15:0]        hdr_wc;
  logic [15:0]        hdr_total, hdr_nfwd;
  logic               fwd_en, in_pld, is_last, is_end, idle_exp;

  // Header field decode and word-count derived sizes
  assign hdr_dt    = dec_data_i[5:0];
  assign hdr_vc    = dec_data_i[7:6];
  assign hdr_wc    = dec_data_i[23:8];
  assign hdr_total = 16'((17'(hdr_wc) + 17'd5) >> 2);
  assign hdr_nfwd  = 16'((17'(hdr_wc) + 17'd3) >> 2);

  // Position of the current payload word within the packet
  assign fwd_en   = VC_EN[pld_vc_q];
  assign in_pld   = idx_q < nfwd_q;
  assign is_last  = idx_q == (nfwd_q - 16'd1);
  assign is_end   = idx_q == (total_q - 16'd1);
  assign idle_exp = idle_q == IDLE_W'(TIMEOUT - 1);

  function automatic logic [3:0] tail_keep(input logic [1:0] m);
    case (m)
      2'd1:    tail_keep = 4'b0001;
      2'd2:    tail_keep = 4'b0011;
      2'd3:    tail_keep = 4'b0111;
      default: tail_keep = 4'b1111;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Packet sequencer with registered outputs
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      nfwd_q         <= '0;
      total_q        <= '0;
      wc_mod_q       <= '0;
      idle_q         <= '0;
      open_q         <= 1'b0;
      pkt_done_q     <= 1'b0;
      pld_valid_q    <= 1'b0;
      pld_data_q     <= '0;
      pld_keep_q     <= '0;
      pld_last_q     <= 1'b0;
      pld_dt_q       <= '0;
      pld_vc_q       <= '0;
      evt_valid_q    <= 1'b0;
      evt_dt_q       <= '0;
      evt_data_q     <= '0;
      pkt_abort_q    <= 1'b0;
      hdr_corr_cnt_q <= '0;
      hdr_err_cnt_q  <= '0;
      abort_cnt_q    <= '0;
    end else begin
      pkt_done_q  <= 1'b0;
      pkt_abort_q <= 1'b0;
      pld_valid_q <= 1'b0;
      pld_last_q  <= 1'b0;
      pld_keep_q  <= '0;
      pld_data_q  <= '0;
      evt_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dec_valid_i) begin
            if (dec_error_i && !dec_error_corrected_i) begin
              hdr_err_cnt_q <= sat_inc(hdr_err_cnt_q);
              pkt_abort_q   <= 1'b1;
              pkt_done_q    <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              if (dec_error_corrected_i) hdr_corr_cnt_q <= sat_inc(hdr_corr_cnt_q);
              if (hdr_dt <= 6'h0F) begin
                evt_valid_q <= 1'b1;
                evt_dt_q    <= hdr_dt;
                evt_data_q  <= hdr_wc;
                pkt_done_q  <= 1'b1;
                state_q     <= S_DONE;
              end else if (hdr_wc > MAX_WC) begin
                abort_cnt_q <= sat_inc(abort_cnt_q);
                pkt_abort_q <= 1'b1;
                pkt_done_q  <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                pld_dt_q <= hdr_dt;
                pld_vc_q <= hdr_vc;
                wc_mod_q <= hdr_wc[1:0];
                nfwd_q   <= hdr_nfwd;
                total_q  <= hdr_total;
                idx_q    <= '0;
                idle_q   <= '0;
                open_q   <= 1'b0;
                state_q  <= S_PAYLOAD;
              end
            end
          end
        end
        S_PAYLOAD: begin
          // A valid word takes priority over a simultaneous timeout
          if (dec_valid_i) begin
            idle_q <= '0;
            idx_q  <= idx_q + 16'd1;
            if (in_pld && fwd_en) begin
              pld_valid_q <= 1'b1;
              pld_data_q  <= dec_data_i;
              pld_last_q  <= is_last;
              pld_keep_q  <= is_last ? tail_keep(wc_mod_q) : 4'b1111;
              open_q      <= !is_last;
            end
            if (is_end) begin
              pkt_done_q <= 1'b1;
              state_q    <= S_DONE;
            end
          end else if (idle_exp) begin
            abort_cnt_q <= sat_inc(abort_cnt_q);
            pkt_abort_q <= 1'b1;
            pkt_done_q  <= 1'b1;
            // Close an open stream with an empty last beat
            if (open_q) begin
              pld_valid_q <= 1'b1;
              pld_last_q  <= 1'b1;
            end
            open_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pkt_done_o     = pkt_done_q;
  assign pld_valid_o    = pld_valid_q;
  assign pld_data_o     = pld_data_q;
  assign pld_keep_o     = pld_keep_q;
  assign pld_last_o     = pld_last_q;
  assign pld_dt_o       = pld_dt_q;
  assign pld_vc_o       = pld_vc_q;
  assign evt_valid_o    = evt_valid_q;
  assign evt_dt_o       = evt_dt_q;
  assign evt_data_o     = evt_data_q;
  assign pkt_abort_o    = pkt_abort_q;
  assign hdr_corr_cnt_o = hdr_corr_cnt_q;
  assign hdr_err_cnt_o  = hdr_err_cnt_q;
  assign abort_cnt_o    = abort_cnt_q;

endmodule

// File: tb/tb_csi2_pkt_ctrl.sv
// tb_csi2_pkt_ctrl: directed packet-level bench for csi2_pkt_ctrl. Each
// stimulus task derives the expected per-cycle outputs from the packet's
// header fields; one compare process checks them after every clock edge.
module tb_csi2_pkt_ctrl;

  localparam int unsigned TO  = 16;
  localparam logic [3:0]  VEN = 4'b1011;

  logic        clk = 1'b0;
  logic        srst_i;
  logic        dec_valid_i;
  logic [31:0] dec_data_i;
  logic        dec_error_i;
  logic        dec_error_corrected_i;
  logic        pkt_done_o, pld_valid_o, pld_last_o, evt_valid_o, pkt_abort_o;
  logic [31:0] pld_data_o;
  logic [3:0]  pld_keep_o;
  logic [5:0]  pld_dt_o, evt_dt_o;
  logic [1:0]  pld_vc_o;
  logic [15:0] evt_data_o, hdr_corr_cnt_o, hdr_err_cnt_o, abort_cnt_o;

  always #5 clk = ~clk;

  csi2_pkt_ctrl #(.MAX_WC(16'd8192), .VC_EN(VEN), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk_i(clk), .srst_i(srst_i), .dec_valid_i(dec_valid_i), .dec_data_i(dec_data_i),
    .dec_error_i(dec_error_i), .dec_error_corrected_i(dec_error_corrected_i),
    .pkt_done_o(pkt_done_o), .pld_valid_o(pld_valid_o), .pld_data_o(pld_data_o),
    .pld_keep_o(pld_keep_o), .pld_last_o(pld_last_o), .pld_dt_o(pld_dt_o),
    .pld_vc_o(pld_vc_o), .evt_valid_o(evt_valid_o), .evt_dt_o(evt_dt_o),
    .evt_data_o(evt_data_o), .pkt_abort_o(pkt_abort_o), .hdr_corr_cnt_o(hdr_corr_cnt_o),
    .hdr_err_cnt_o(hdr_err_cnt_o), .abort_cnt_o(abort_cnt_o));

  typedef struct {
    logic        done, abort, pv, last, ev;
    logic [31:0] pdata;
    logic [3:0]  keep;
    logic [5:0]  pdt, evdt;
    logic [1:0]  pvc;
    logic [15:0] evdata;
    int          ccorr, cerr, cabort;
  } exp_t;

  exp_t       exp_n, exp_cur;
  int         e_corr = 0, e_err = 0, e_abort = 0;
  int         passed = 0, total = 0;
  bit         chk_en = 1'b0;
  int         beats = 0;
  logic [3:0] last_keep = 4'h0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endfunction

  function automatic void clr_exp();
    exp_n.done = 0; exp_n.abort = 0; exp_n.pv = 0; exp_n.last = 0; exp_n.ev = 0;
    exp_n.pdata = '0; exp_n.keep = '0; exp_n.pdt = '0; exp_n.evdt = '0;
    exp_n.pvc = '0; exp_n.evdata = '0;
  endfunction

  function automatic logic [3:0] keep_of(int wc);
    case (wc % 4)
      1:       keep_of = 4'b0001;
      2:       keep_of = 4'b0011;
      3:       keep_of = 4'b0111;
      default: keep_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] hdr(logic [5:0] dt, logic [1:0] vc, logic [15:0] wc);
    hdr = {8'h3C, wc, vc, dt};
  endfunction

  // Drive one input cycle; exp_n describes the outputs that word must produce
  task automatic step(input logic v, input logic [31:0] d, input logic e, input logic c);
    @(negedge clk);
    dec_valid_i = v; dec_data_i = d; dec_error_i = e; dec_error_corrected_i = c;
    exp_cur = exp_n;
    exp_cur.ccorr = e_corr; exp_cur.cerr = e_err; exp_cur.cabort = e_abort;
    clr_exp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic send_short(input logic [5:0] dt, input logic [15:0] wc, input logic corr);
    if (corr) e_corr++;
    exp_n.ev = 1; exp_n.evdt = dt; exp_n.evdata = wc; exp_n.done = 1;
    step(1'b1, hdr(dt, 2'd0, wc), corr, corr);
    step(1'b1, $urandom, 1'b0, 1'b0);  // arrives during DONE, must be ignored
  endtask

  task automatic send_err();
    e_err++;
    exp_n.abort = 1; exp_n.done = 1;
    step(1'b1, hdr(6'h2B, 2'd0, 16'd8), 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Long packet: nsend words after the header, gap idle cycles before each
  task automatic send_long(input logic [5:0] dt, input logic [1:0] vc, input int wc,
                           input int nsend, input int gap, input logic corr);
    int nfwd, tot;
    logic [31:0] d;
    nfwd = (wc + 3) / 4;
    tot  = (wc + 5) / 4;
    if (corr) e_corr++;
    if (wc > 8192) begin
      e_abort++;
      exp_n.abort = 1; exp_n.done = 1;
      step(1'b1, hdr(dt, vc, 16'(wc)), corr, corr);
      step(1'b1, $urandom, 1'b0, 1'b0);
      return;
    end
    step(1'b1, hdr(dt, vc, 16'(wc)), corr, corr);
    for (int i = 0; i < nsend; i++) begin
      idle(gap);
      d = $urandom;
      if (VEN[vc] && i < nfwd) begin
        exp_n.pv = 1; exp_n.pdata = d; exp_n.pdt = dt; exp_n.pvc = vc;
        exp_n.last = (i == nfwd - 1);
        exp_n.keep = (i == nfwd - 1) ? keep_of(wc) : 4'b1111;
      end
      if (i == tot - 1) exp_n.done = 1;
      step(1'b1, d, 1'b0, 1'b0);
    end
    if (nsend < tot) begin
      idle(TO - 1);
      e_abort++;
      exp_n.abort = 1; exp_n.done = 1;
      if (VEN[vc] && nsend > 0 && nsend < nfwd) begin
        exp_n.pv = 1; exp_n.last = 1; exp_n.keep = 4'b0000; exp_n.pdata = '0;
        exp_n.pdt = dt; exp_n.pvc = vc;
      end
      step(1'b0, 32'h0, 1'b0, 1'b0);
    end
    step(1'b1, $urandom, 1'b0, 1'b0);
  endtask

  // Per-cycle compare against the packet-level expectation
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("pkt_done", 32'(pkt_done_o), 32'(exp_cur.done));
      chk("pkt_abort", 32'(pkt_abort_o), 32'(exp_cur.abort));
      chk("pld_valid", 32'(pld_valid_o), 32'(exp_cur.pv));
      chk("evt_valid", 32'(evt_valid_o), 32'(exp_cur.ev));
      if (exp_cur.pv) begin
        chk("pld_data", pld_data_o, exp_cur.pdata);
        chk("pld_keep", 32'(pld_keep_o), 32'(exp_cur.keep));
        chk("pld_last", 32'(pld_last_o), 32'(exp_cur.last));
        chk("pld_dt", 32'(pld_dt_o), 32'(exp_cur.pdt));
        chk("pld_vc", 32'(pld_vc_o), 32'(exp_cur.pvc));
      end
      if (exp_cur.ev) begin
        chk("evt_dt", 32'(evt_dt_o), 32'(exp_cur.evdt));
        chk("evt_data", 32'(evt_data_o), 32'(exp_cur.evdata));
      end
      chk("hdr_corr_cnt", 32'(hdr_corr_cnt_o), 32'(exp_cur.ccorr));
      chk("hdr_err_cnt", 32'(hdr_err_cnt_o), 32'(exp_cur.cerr));
      chk("abort_cnt", 32'(abort_cnt_o), 32'(exp_cur.cabort));
    end
    if (pld_valid_o) begin
      beats++;
      last_keep = pld_keep_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_exp();
    exp_cur = exp_n; exp_cur.ccorr = 0; exp_cur.cerr = 0; exp_cur.cabort = 0;
    srst_i = 1'b1; dec_valid_i = 1'b0; dec_data_i = '0;
    dec_error_i = 1'b0; dec_error_corrected_i = 1'b0;
    #12;
    chk("reset_done", 32'(pkt_done_o), 32'd0);
    chk("reset_pv", 32'(pld_valid_o), 32'd0);
    chk("reset_evt", 32'(evt_valid_o), 32'd0);
    chk("reset_cnt", 32'(abort_cnt_o), 32'd0);
    repeat (2) @(negedge clk);
    srst_i = 1'b0;
    idle(1);
    chk_en = 1'b1;
    idle(2);

    beats = 0;
    send_short(6'h00, 16'h0005, 1'b0);               // FS
    chk("fs_beats", 32'(beats), 32'd0);

    beats = 0;
    send_long(6'h2B, 2'd0, 10, 3, 0, 1'b0);          // RAW10, 3 beats
    chk("wc10_beats", 32'(beats), 32'd3);
    chk("wc10_keep", 32'(last_keep), 32'h3);

    beats = 0;
    send_long(6'h2B, 2'd0, 4, 2, 0, 1'b1);           // corrected header
    chk("corr_cnt_lit", 32'(hdr_corr_cnt_o), 32'd1);
    chk("wc4_beats", 32'(beats), 32'd1);
    chk("wc4_keep", 32'(last_keep), 32'hF);

    send_err();
    chk("err_cnt_lit", 32'(hdr_err_cnt_o), 32'd1);
    send_short(6'h03, 16'h1234, 1'b0);               // LE right after bad header

    send_long(6'h2B, 2'd0, 16'h4000, 0, 0, 1'b0);    // oversize
    chk("abort_lit1", 32'(abort_cnt_o), 32'd1);
    send_long(6'h2B, 2'd0, 8193, 0, 0, 1'b0);        // one past MAX_WC

    beats = 0;
    send_long(6'h2B, 2'd0, 16, 2, 0, 1'b0);          // stall -> timeout
    chk("stall_beats", 32'(beats), 32'd3);
    chk("stall_keep", 32'(last_keep), 32'h0);
    chk("abort_lit3", 32'(abort_cnt_o), 32'd3);

    beats = 0;
    send_long(6'h2B, 2'd2, 12, 4, 0, 1'b0);          // disabled VC
    chk("vc2_beats", 32'(beats), 32'd0);

    beats = 0;
    send_long(6'h10, 2'd3, 0, 1, 0, 1'b0);           // WC=0
    chk("wc0_beats", 32'(beats), 32'd0);

    beats = 0;
    send_long(6'h12, 2'd1, 7, 3, TO - 1, 1'b0);      // word on expiry cycle wins
    chk("gap_beats", 32'(beats), 32'd2);
    chk("gap_keep", 32'(last_keep), 32'h7);

    send_short(6'h0F, 16'hBEEF, 1'b1);               // largest short DT
    send_long(6'h2B, 2'd0, 9, 3, 0, 1'b0);

    // Asynchronous reset in the middle of a payload
    step(1'b1, hdr(6'h2B, 2'd0, 16'd32), 1'b0, 1'b0);
    exp_n.pv = 1; exp_n.pdata = 32'hCAFE0001; exp_n.pdt = 6'h2B; exp_n.keep = 4'hF;
    step(1'b1, 32'hCAFE0001, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk_en = 1'b0;
    chk("pre_rst_pv", 32'(pld_valid_o), 32'd1);
    srst_i = 1'b1;
    dec_valid_i = 1'b0;
    #1;
    chk("rst_pv", 32'(pld_valid_o), 32'd0);
    chk("rst_dt", 32'(pld_dt_o), 32'd0);
    chk("rst_corr", 32'(hdr_corr_cnt_o), 32'd0);
    chk("rst_abort", 32'(abort_cnt_o), 32'd0);
    e_corr = 0; e_err = 0; e_abort = 0;
    repeat (2) @(negedge clk);
    srst_i = 1'b0;
    idle(1);
    chk_en = 1'b1;
    idle(TO + 2);                                    // no done/last/abort after reset
    send_short(6'h02, 16'h0042, 1'b0);               // LS parsed from IDLE
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
